// File: rtl/midi_note_ctrl.sv
// MIDI note-on/note-off parser and voice allocator for NVOICE oscillators.
// Optional round-robin voice stealing is enabled by defining VOICE_STEAL_EN.

`ifndef OSC_CNT_BW
`define OSC_CNT_BW 22
`endif

`ifndef NOTE_HALF_0
`define NOTE_HALF_0  22'd3057805
`define NOTE_HALF_1  22'd2886169
`define NOTE_HALF_2  22'd2724202
`define NOTE_HALF_3  22'd2571302
`define NOTE_HALF_4  22'd2426974
`define NOTE_HALF_5  22'd2290761
`define NOTE_HALF_6  22'd2162199
`define NOTE_HALF_7  22'd2040833
`define NOTE_HALF_8  22'd1926289
`define NOTE_HALF_9  22'd1818182
`define NOTE_HALF_10 22'd1716137
`define NOTE_HALF_11 22'd1619811
`endif

module midi_note_ctrl #(
  parameter int          NVOICE  = 4,
  parameter logic [3:0]  MIDI_CH = 4'd0
) (
  input  logic                   clk_i,
  input  logic                   nrst_i,
  input  logic                   byteValid_i,
  input  logic [7:0]             byte_i,
  input  logic [NVOICE-1:0]      activeMask_i,
  output logic                   noteOnStrb_o,
  output logic                   noteOffStrb_o,
  output logic [NVOICE-1:0]      ch_o,
  output logic [`OSC_CNT_BW-1:0] halfCntPeriod_o,
  output logic [1:0]             parser_state
);

  localparam int HW = `OSC_CNT_BW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA1  = 2'd1,
    DATA2  = 2'd2,
    IGNORE = 2'd3
  } state_t;

  state_t     state, state_n;
  logic       type_on;
  logic [6:0] note_q;
  logic [6:0] notes [NVOICE];

  logic is_rt, is_ours;
  logic latch_type, latch_note, fire;

  assign parser_state = state;

  assign is_rt   = byte_i >= 8'hF8;
  assign is_ours = byte_i[7] && (byte_i[7:4] == 4'h9 || byte_i[7:4] == 4'h8) &&
                   (byte_i[3:0] == MIDI_CH);

  always_ff @(posedge clk_i) begin
    if (!nrst_i) state <= IDLE;
    else         state <= state_n;
  end

  // Data bytes in DATA2 loop back to DATA1 so running status works.
  always_comb begin
    state_n    = state;
    latch_type = 1'b0;
    latch_note = 1'b0;
    fire       = 1'b0;
    if (byteValid_i && !is_rt) begin
      if (byte_i[7]) begin
        if (is_ours) begin
          latch_type = 1'b1;
          state_n    = DATA1;
        end else begin
          state_n = IGNORE;
        end
      end else begin
        case (state)
          DATA1: begin
            latch_note = 1'b1;
            state_n    = DATA2;
          end
          DATA2: begin
            fire    = 1'b1;
            state_n = DATA1;
          end
          default: state_n = state;
        endcase
      end
    end
  end

  function automatic logic [HW-1:0] note_half(input logic [6:0] n);
    logic [3:0]    k;
    logic [3:0]    oct;
    logic [HW-1:0] base;
    k   = 4'(n % 7'd12);
    oct = 4'(n / 7'd12);
    case (k)
      4'd0:    base = `NOTE_HALF_0;
      4'd1:    base = `NOTE_HALF_1;
      4'd2:    base = `NOTE_HALF_2;
      4'd3:    base = `NOTE_HALF_3;
      4'd4:    base = `NOTE_HALF_4;
      4'd5:    base = `NOTE_HALF_5;
      4'd6:    base = `NOTE_HALF_6;
      4'd7:    base = `NOTE_HALF_7;
      4'd8:    base = `NOTE_HALF_8;
      4'd9:    base = `NOTE_HALF_9;
      4'd10:   base = `NOTE_HALF_10;
      default: base = `NOTE_HALF_11;
    endcase
    return base >> oct;
  endfunction

  logic [NVOICE-1:0] match, match_oh, free, free_oh, sel;
  logic              all_held, vel_zero, do_on, do_off;
  logic [HW-1:0]     half_sel;

`ifdef VOICE_STEAL_EN
  localparam int PW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  logic [PW-1:0]     steal_ptr;
  logic [NVOICE-1:0] steal_oh;
  logic              steal_adv;

  always_comb begin
    for (int i = 0; i < NVOICE; i++) steal_oh[i] = (steal_ptr == PW'(i));
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i)        steal_ptr <= '0;
    else if (steal_adv) steal_ptr <= (steal_ptr == PW'(NVOICE - 1)) ? '0 : steal_ptr + 1'b1;
  end
`endif

  always_comb begin
    for (int i = 0; i < NVOICE; i++) match[i] = activeMask_i[i] && (notes[i] == note_q);
  end

  assign free     = ~activeMask_i;
  assign match_oh = match & (~match + NVOICE'(1));
  assign free_oh  = free & (~free + NVOICE'(1));
  assign all_held = &activeMask_i;
  assign vel_zero = (byte_i[6:0] == 7'd0);
  assign half_sel = note_half(note_q);

  // A full voice set takes the steal/drop path even if a held voice has the note.
  always_comb begin
    sel    = '0;
    do_on  = 1'b0;
    do_off = 1'b0;
`ifdef VOICE_STEAL_EN
    steal_adv = 1'b0;
`endif
    if (fire) begin
      if (type_on && !vel_zero) begin
        if (all_held) begin
`ifdef VOICE_STEAL_EN
          sel       = steal_oh;
          do_on     = 1'b1;
          steal_adv = 1'b1;
`else
          do_on = 1'b0;
`endif
        end else if (|match) begin
          sel   = match_oh;
          do_on = 1'b1;
        end else begin
          sel   = free_oh;
          do_on = 1'b1;
        end
      end else if (|match) begin
        sel    = match_oh;
        do_off = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      type_on <= 1'b0;
      note_q  <= '0;
      for (int i = 0; i < NVOICE; i++) notes[i] <= '0;
    end else begin
      if (latch_type) type_on <= (byte_i[7:4] == 4'h9);
      if (latch_note) note_q  <= byte_i[6:0];
      if (do_on) begin
        for (int i = 0; i < NVOICE; i++) if (sel[i]) notes[i] <= note_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      noteOnStrb_o    <= 1'b0;
      noteOffStrb_o   <= 1'b0;
      ch_o            <= '0;
      halfCntPeriod_o <= '0;
    end else begin
      noteOnStrb_o  <= do_on;
      noteOffStrb_o <= do_off;
      if (do_on || do_off) begin
        ch_o            <= sel;
        halfCntPeriod_o <= half_sel;
      end
    end
  end

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Bench for midi_note_ctrl: directed MIDI scenarios plus randomized traffic
// checked against a message-level model of note parsing and voice allocation.

`ifndef OSC_CNT_BW
`define OSC_CNT_BW 22
`endif

`ifndef NOTE_HALF_0
`define NOTE_HALF_0  22'd3057805
`define NOTE_HALF_1  22'd2886169
`define NOTE_HALF_2  22'd2724202
`define NOTE_HALF_3  22'd2571302
`define NOTE_HALF_4  22'd2426974
`define NOTE_HALF_5  22'd2290761
`define NOTE_HALF_6  22'd2162199
`define NOTE_HALF_7  22'd2040833
`define NOTE_HALF_8  22'd1926289
`define NOTE_HALF_9  22'd1818182
`define NOTE_HALF_10 22'd1716137
`define NOTE_HALF_11 22'd1619811
`endif

module tb_midi_note_ctrl;
  localparam int         NV = 4;
  localparam logic [3:0] CH = 4'd0;
  localparam int         HW = `OSC_CNT_BW;
  localparam int         W  = 2 + NV + HW;

  // clock / reset
  logic          clk = 1'b0;
  logic          nrst;
  logic          byte_valid;
  logic [7:0]    byte_d;
  logic [NV-1:0] mask;
  logic          note_on, note_off;
  logic [NV-1:0] ch;
  logic [HW-1:0] half;
  logic [1:0]    parser_state;

  always #5 clk = ~clk;

  midi_note_ctrl #(.NVOICE(NV), .MIDI_CH(CH)) dut (
    .clk_i           (clk),
    .nrst_i          (nrst),
    .byteValid_i     (byte_valid),
    .byte_i          (byte_d),
    .activeMask_i    (mask),
    .noteOnStrb_o    (note_on),
    .noteOffStrb_o   (note_off),
    .ch_o            (ch),
    .halfCntPeriod_o (half),
    .parser_state    (parser_state)
  );

  // scoreboard and reference model state
  int            checks;
  int            errors;
  int            base_tab[12];
  int            m_status;
  logic [7:0]    m_data[$];
  int            voice_note[NV];
  int            steal_ptr;
  logic [NV-1:0] m_ch;
  logic [HW-1:0] m_half;
  logic [W-1:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] ref_half(input int n);
    return HW'(base_tab[n % 12] >> (n / 12));
  endfunction

  task automatic model_reset();
    m_status = -1;
    m_data.delete();
    for (int i = 0; i < NV; i++) voice_note[i] = 0;
    steal_ptr = 0;
    m_ch      = '0;
    m_half    = '0;
    exp_q.delete();
  endtask

  // Message-level model: collect two data bytes after an accepted status.
  task automatic model_byte(input logic [7:0] b);
    logic on, off;
    int   note, vel, v;
    on = 1'b0;
    off = 1'b0;
    if (b >= 8'hF8) begin
      on = 1'b0;
    end else if (b[7]) begin
      if ((b[7:4] == 4'h9 || b[7:4] == 4'h8) && b[3:0] == CH) m_status = int'(b);
      else m_status = -1;
      m_data.delete();
    end else if (m_status >= 0) begin
      m_data.push_back(b);
      if (m_data.size() == 2) begin
        note = int'(m_data[0]);
        vel  = int'(m_data[1]);
        m_data.delete();
        v = -1;
        if ((m_status >> 4) == 9 && vel != 0) begin
          if (mask == '1) begin
`ifdef VOICE_STEAL_EN
            v = steal_ptr;
            steal_ptr = (steal_ptr + 1) % NV;
`endif
          end else begin
            for (int i = 0; i < NV; i++) if (mask[i] && voice_note[i] == note) begin v = i; break; end
            if (v < 0) for (int i = 0; i < NV; i++) if (!mask[i]) begin v = i; break; end
          end
          if (v >= 0) begin
            on = 1'b1;
            voice_note[v] = note;
          end
        end else begin
          for (int i = 0; i < NV; i++) if (mask[i] && voice_note[i] == note) begin v = i; break; end
          if (v >= 0) off = 1'b1;
        end
        if (v >= 0) begin
          m_ch   = NV'(1) << v;
          m_half = ref_half(note);
        end
      end
    end
    exp_q.push_back({on, off, m_ch, m_half});
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    chk({tag, ".on"},   32'(note_on),  32'(e[W-1]));
    chk({tag, ".off"},  32'(note_off), 32'(e[W-2]));
    chk({tag, ".ch"},   32'(ch),       32'(e[W-3 -: NV]));
    chk({tag, ".half"}, 32'(half),     32'(e[HW-1:0]));
    chk({tag, ".excl"}, 32'(note_on & note_off), 32'd0);
    chk({tag, ".1hot"}, 32'($countones(ch) <= 1), 32'd1);
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input string tag);
    model_byte(b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_d     = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    exp_q.push_back({1'b0, 1'b0, m_ch, m_half});
    @(negedge clk);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nrst       = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    chk({tag, ".on"},    32'(note_on),      32'd0);
    chk({tag, ".off"},   32'(note_off),     32'd0);
    chk({tag, ".ch"},    32'(ch),           32'd0);
    chk({tag, ".half"},  32'(half),         32'd0);
    chk({tag, ".state"}, 32'(parser_state), 32'd0);
  endtask

  initial begin
    int kind, note, vel;
    checks = 0;
    errors = 0;
    base_tab = '{`NOTE_HALF_0, `NOTE_HALF_1, `NOTE_HALF_2, `NOTE_HALF_3,
                 `NOTE_HALF_4, `NOTE_HALF_5, `NOTE_HALF_6, `NOTE_HALF_7,
                 `NOTE_HALF_8, `NOTE_HALF_9, `NOTE_HALF_10, `NOTE_HALF_11};
    nrst       = 1'b0;
    byte_valid = 1'b0;
    byte_d     = 8'h00;
    mask       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("reset");

    // note 69 onto voice 0, strobe lasts one cycle
    mask = 4'b0000;
    send_byte(8'h90, "t1.s");
    send_byte(8'h45, "t1.n");
    send_byte(8'h64, "t1.v");
    chk("t1.on_pulse", 32'(note_on), 32'd1);
    chk("t1.ch_dir",   32'(ch),      32'd1);
    chk("t1.half_dir", 32'(half),    32'(`NOTE_HALF_9 >> 5));
    idle_cycle("t1.after");

    // note on then running-status note off with velocity 0
    do_reset("t2.rst");
    send_byte(8'h90, "t2.s");
    send_byte(8'h3C, "t2.n");
    send_byte(8'h40, "t2.v");
    mask = 4'b0001;
    send_byte(8'h3C, "t2.rn");
    send_byte(8'h00, "t2.rv");
    chk("t2.off_pulse", 32'(note_off), 32'd1);
    chk("t2.ch_dir",    32'(ch),       32'd1);

    // wrong channel and a control change are ignored
    do_reset("t3.rst");
    mask = 4'b0000;
    send_byte(8'h91, "t3.s");
    send_byte(8'h3C, "t3.n");
    send_byte(8'h40, "t3.v");
    chk("t3.no_strobe", 32'({note_on, note_off}), 32'd0);
    send_byte(8'hB0, "t3.cs");
    send_byte(8'h07, "t3.cn");
    send_byte(8'h7F, "t3.cv");
    chk("t3.cc_no_strobe", 32'({note_on, note_off}), 32'd0);

    // realtime bytes interleaved inside a message
    do_reset("t4.rst");
    send_byte(8'h90, "t4.s");
    send_byte(8'hF8, "t4.rt1");
    send_byte(8'h3C, "t4.n");
    send_byte(8'hFE, "t4.rt2");
    send_byte(8'h40, "t4.v");
    chk("t4.on_pulse", 32'(note_on), 32'd1);
    chk("t4.half_dir", 32'(half),    32'(`NOTE_HALF_0 >> 5));

    // all voices held
    do_reset("t5.rst");
    mask = 4'b1111;
    send_byte(8'h90, "t5.s");
    send_byte(8'h32, "t5.n1");
    send_byte(8'h40, "t5.v1");
`ifdef VOICE_STEAL_EN
    chk("t5.steal0", 32'(ch), 32'd1);
`else
    chk("t5.drop0", 32'(note_on), 32'd0);
`endif
    send_byte(8'h32, "t5.n2");
    send_byte(8'h40, "t5.v2");
`ifdef VOICE_STEAL_EN
    chk("t5.steal1", 32'(ch), 32'd2);
`else
    chk("t5.drop1", 32'(note_on), 32'd0);
`endif

    // reset in the middle of a message drops it
    do_reset("t6.rst");
    mask = 4'b0000;
    send_byte(8'h90, "t6.s");
    send_byte(8'h3C, "t6.n");
    do_reset("t6.mid");
    send_byte(8'h40, "t6.v");
    chk("t6.no_strobe", 32'({note_on, note_off}), 32'd0);
    chk("t6.ch_zero",   32'(ch),   32'd0);
    chk("t6.half_zero", 32'(half), 32'd0);

    // randomized traffic
    do_reset("rnd.rst");
    for (int m = 0; m < 120; m++) begin
      mask = NV'($urandom_range(0, 15));
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1, 2: send_byte(8'h90, "rnd.s");
        3:       send_byte(8'h80, "rnd.s");
        4:       send_byte(8'h91, "rnd.s");
        5:       send_byte(8'hB0, "rnd.s");
        default: ;
      endcase
      note = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(58, 62);
      vel  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127);
      send_byte(8'(note), "rnd.n");
      if ($urandom_range(0, 4) == 0) send_byte(8'(8'hF8 + $urandom_range(0, 7)), "rnd.rt");
      send_byte(8'(vel), "rnd.v");
    end
    idle_cycle("rnd.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
